toaster_ctrl: RTL and testbench

Cook-cycle sequencer for the timer_pwm heater datapath.
- Latches the keypad entry (cook time, duty) and loads the timer through its write/write_ack handshake.
- Runs a fixed full-power preheat phase, then the user cook phase. Supports pause/resume and abort.
- Raises a timed buzzer on completion.
- Sits between the keypad decoder and timer_pwm; it is the only driver of the timer's write, Time, start and DC inputs.

---
 rtl/toaster_pkg.sv | 33 +++
 rtl/toaster_ctrl_timer_loader.sv | 46 ++++
 rtl/toaster_ctrl.sv | 165 ++++++++++++++++
 tb/tb_toaster_ctrl.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toaster_pkg.sv
// Shared types and constants for the toaster cook-cycle controller.
// The time type is also meant for the keypad decoder and timer_pwm blocks.
package toaster_pkg;

    localparam int TIME_W  = 10;
    localparam int DC_W    = 8;
    localparam int DC_FULL = 200;

    typedef logic [TIME_W-1:0] time_t;
    typedef logic [DC_W-1:0]   dc_t;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_PRE,
        PREHEAT,
        LOAD_COOK,
        COOK,
        PAUSE,
        LOAD_ZERO,
        DONE,
        ERROR
    } ctrl_state_t;

    typedef enum logic {
        PHASE_PRE,
        PHASE_COOK
    } phase_t;

    function automatic dc_t clamp_dc(input dc_t dc, input dc_t max_dc);
        return (dc > max_dc) ? max_dc : dc;
    endfunction

endpackage

// File: rtl/toaster_ctrl_timer_loader.sv
// Write/write_ack handshake toward timer_pwm with an ack timeout.
// done and timeout are single-cycle strobes on the edge where tmr_write drops.
module timer_loader
    import toaster_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  go,
    input  time_t value,
    input  logic  tmr_write_ack,
    output logic  tmr_write,
    output time_t tmr_time,
    output logic  done,
    output logic  timeout
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;

    assign done    = tmr_write && tmr_write_ack;
    assign timeout = tmr_write && !tmr_write_ack && (wait_cnt == CW'(ACK_TIMEOUT - 1));

    // tmr_time is captured once at arm time so it cannot move while write is high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_write <= 1'b0;
            tmr_time  <= '0;
            wait_cnt  <= '0;
        end else if (tmr_write) begin
            if (tmr_write_ack || timeout) begin
                tmr_write <= 1'b0;
                wait_cnt  <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end else if (go) begin
            tmr_write <= 1'b1;
            tmr_time  <= value;
            wait_cnt  <= '0;
        end
    end

endmodule

// File: rtl/toaster_ctrl.sv
// Cook-cycle sequencer: keypad latch, preheat, cook, pause/resume, abort and buzzer.
// All outputs are registered from the next state so they move with the state.
module toaster_ctrl
    import toaster_pkg::*;
#(
    parameter int PREHEAT_S   = 10,
    parameter int PREHEAT_DC  = DC_FULL,
    parameter int MAX_DC      = DC_FULL,
    parameter int ACK_TIMEOUT = 16,
    parameter int DONE_CYCLES = 4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [9:0]  key_time,
    input  logic [7:0]  key_dc,
    input  logic        start_btn,
    input  logic        stop_btn,
    input  logic [11:0] tmr_tled,
    input  logic        tmr_write_ack,
    output logic        tmr_write,
    output logic [9:0]  tmr_time,
    output logic        tmr_start,
    output logic [7:0]  tmr_dc,
    output logic        busy,
    output logic        buzzer,
    output logic        error
);

    localparam int DCW = $clog2(DONE_CYCLES + 1);

    ctrl_state_t    state;
    ctrl_state_t    state_next;
    time_t          time_lat;
    dc_t            dc_lat;
    phase_t         resume_phase;
    logic           phase_first;
    logic [DCW-1:0] done_cnt;

    logic  load_go;
    logic  load_done;
    logic  load_timeout;
    time_t load_value;
    logic  zero_seen;
    logic  done_last;

    assign load_go   = (state == LOAD_PRE) || (state == LOAD_COOK) || (state == LOAD_ZERO);
    assign zero_seen = !phase_first && (tmr_tled == '0);
    assign done_last = (done_cnt == DCW'(DONE_CYCLES - 1));

    always_comb begin
        load_value = '0;
        case (state)
            LOAD_PRE:  load_value = time_t'(PREHEAT_S);
            LOAD_COOK: load_value = time_lat;
            default:   load_value = '0;
        endcase
    end

    timer_loader #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_loader (
        .clk           (clk),
        .reset         (reset),
        .go            (load_go),
        .value         (load_value),
        .tmr_write_ack (tmr_write_ack),
        .tmr_write     (tmr_write),
        .tmr_time      (tmr_time),
        .done          (load_done),
        .timeout       (load_timeout)
    );

    // stop_btn is tested first everywhere so it wins over a simultaneous start
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!stop_btn && start_btn && (time_lat != '0))
                    state_next = LOAD_PRE;
            end
            LOAD_PRE: begin
                if (load_timeout)   state_next = ERROR;
                else if (load_done) state_next = PREHEAT;
            end
            LOAD_COOK: begin
                if (load_timeout)   state_next = ERROR;
                else if (load_done) state_next = COOK;
            end
            LOAD_ZERO: begin
                if (load_timeout)   state_next = ERROR;
                else if (load_done) state_next = IDLE;
            end
            PREHEAT: begin
                if (stop_btn)       state_next = PAUSE;
                else if (zero_seen) state_next = LOAD_COOK;
            end
            COOK: begin
                if (stop_btn)       state_next = PAUSE;
                else if (zero_seen) state_next = DONE;
            end
            PAUSE: begin
                if (stop_btn)
                    state_next = LOAD_ZERO;
                else if (start_btn)
                    state_next = (resume_phase == PHASE_PRE) ? PREHEAT : COOK;
            end
            DONE: begin
                if (stop_btn || done_last) state_next = IDLE;
            end
            ERROR: begin
                if (stop_btn) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // phase_first masks the stale pre-load tLED value on the first cycle of a phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            time_lat     <= '0;
            dc_lat       <= '0;
            resume_phase <= PHASE_PRE;
            phase_first  <= 1'b0;
            done_cnt     <= '0;
        end else begin
            if ((state == IDLE) && key_valid) begin
                time_lat <= key_time;
                dc_lat   <= clamp_dc(key_dc, dc_t'(MAX_DC));
            end
            if ((state == PREHEAT) && (state_next == PAUSE))
                resume_phase <= PHASE_PRE;
            else if ((state == COOK) && (state_next == PAUSE))
                resume_phase <= PHASE_COOK;
            phase_first <= (state_next != state);
            if ((state == DONE) && (state_next == DONE))
                done_cnt <= done_cnt + 1'b1;
            else
                done_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tmr_start <= 1'b0;
            tmr_dc    <= '0;
            busy      <= 1'b0;
            buzzer    <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_next;
            tmr_start <= (state_next == PREHEAT) || (state_next == COOK);
            busy      <= (state_next != IDLE);
            buzzer    <= (state_next == DONE);
            error     <= (state_next == ERROR);
            case (state_next)
                PREHEAT: tmr_dc <= dc_t'(PREHEAT_DC);
                COOK:    tmr_dc <= dc_lat;
                default: tmr_dc <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_toaster_ctrl.sv
// Directed bench for toaster_ctrl with a simple timer_pwm ack responder.
// Stimulus and sampling happen 2 time units after each rising edge.
module tb_toaster_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [9:0]  key_time = '0;
    logic [7:0]  key_dc = '0;
    logic        start_btn = 1'b0;
    logic        stop_btn = 1'b0;
    logic [11:0] tmr_tled = '0;
    logic        tmr_write_ack = 1'b0;
    logic        tmr_write;
    logic [9:0]  tmr_time;
    logic        tmr_start;
    logic [7:0]  tmr_dc;
    logic        busy;
    logic        buzzer;
    logic        error;

    int checks = 0;
    int passed = 0;

    int         ack_delay = 1;
    bit         ack_enable = 1'b1;
    int         ack_wait = 0;
    int         write_count = 0;
    logic       write_prev = 1'b0;
    logic [9:0] last_time = '0;
    bit         time_unstable = 1'b0;

    toaster_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .key_valid     (key_valid),
        .key_time      (key_time),
        .key_dc        (key_dc),
        .start_btn     (start_btn),
        .stop_btn      (stop_btn),
        .tmr_tled      (tmr_tled),
        .tmr_write_ack (tmr_write_ack),
        .tmr_write     (tmr_write),
        .tmr_time      (tmr_time),
        .tmr_start     (tmr_start),
        .tmr_dc        (tmr_dc),
        .busy          (busy),
        .buzzer        (buzzer),
        .error         (error)
    );

    always #5 clk = ~clk;

    // Timer model: counts writes, watches Time stability, acks after ack_delay cycles
    always @(negedge clk) begin
        if (tmr_write === 1'b1 && write_prev !== 1'b1) begin
            write_count = write_count + 1;
            last_time   = tmr_time;
        end
        if (tmr_write === 1'b1 && tmr_time !== last_time)
            time_unstable = 1'b1;
        write_prev = tmr_write;
        if (tmr_write === 1'b1 && ack_enable) begin
            ack_wait      = ack_wait + 1;
            tmr_write_ack = (ack_wait == ack_delay);
        end else begin
            ack_wait      = 0;
            tmr_write_ack = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_btn = 1'b1;
        step();
        stop_btn = 1'b0;
    endtask

    task automatic enter_key(input logic [9:0] t, input logic [7:0] d);
        key_valid = 1'b1;
        key_time  = t;
        key_dc    = d;
        step();
        key_valid = 1'b0;
    endtask

    // From IDLE with a nonzero latched time and 1-cycle ack, ends in COOK
    task automatic run_to_cook();
        pulse_start();
        tmr_tled = 12'h010;
        step();
        step();
        step();
        step();
        tmr_tled = 12'h000;
        step();
        step();
        tmr_tled = 12'h005;
        step();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({tmr_write, tmr_start, busy, buzzer, error, tmr_time, tmr_dc} !== '0)
            $display("[TB] FAIL reset_outputs: got write=%b start=%b busy=%b buzzer=%b error=%b time=%0d dc=%0d, want all 0",
                     tmr_write, tmr_start, busy, buzzer, error, tmr_time, tmr_dc);
        else passed++;
        step();
        step();
        reset = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || tmr_write !== 1'b0)
            $display("[TB] FAIL reset_release_idle: busy=%b write=%b, want 0 0", busy, tmr_write);
        else passed++;
    endtask

    task automatic test_normal_cycle();
        int n;
        int wc;
        wc = write_count;
        enter_key(10'd3, 8'd100);
        tmr_tled = 12'h010;
        pulse_start();
        checks++;
        if (busy !== 1'b1 || tmr_write !== 1'b0 || tmr_start !== 1'b0)
            $display("[TB] FAIL norm_load_pre_entry: busy=%b write=%b start=%b, want 1 0 0", busy, tmr_write, tmr_start);
        else passed++;
        step();
        checks++;
        if (tmr_write !== 1'b1 || tmr_time !== 10'd10)
            $display("[TB] FAIL norm_pre_write: write=%b time=%0d, want 1 10", tmr_write, tmr_time);
        else passed++;
        step();
        checks++;
        if (tmr_write !== 1'b0 || tmr_start !== 1'b1 || tmr_dc !== 8'd200)
            $display("[TB] FAIL norm_preheat: write=%b start=%b dc=%0d, want 0 1 200", tmr_write, tmr_start, tmr_dc);
        else passed++;
        repeat (3) step();
        checks++;
        if (tmr_start !== 1'b1 || tmr_dc !== 8'd200)
            $display("[TB] FAIL norm_preheat_hold: start=%b dc=%0d, want 1 200", tmr_start, tmr_dc);
        else passed++;
        tmr_tled = 12'h000;
        step();
        checks++;
        if (tmr_start !== 1'b0 || busy !== 1'b1)
            $display("[TB] FAIL norm_load_cook_entry: start=%b busy=%b, want 0 1", tmr_start, busy);
        else passed++;
        step();
        checks++;
        if (tmr_write !== 1'b1 || tmr_time !== 10'd3)
            $display("[TB] FAIL norm_cook_write: write=%b time=%0d, want 1 3", tmr_write, tmr_time);
        else passed++;
        tmr_tled = 12'h003;
        step();
        checks++;
        if (tmr_write !== 1'b0 || tmr_start !== 1'b1 || tmr_dc !== 8'd100)
            $display("[TB] FAIL norm_cook: write=%b start=%b dc=%0d, want 0 1 100", tmr_write, tmr_start, tmr_dc);
        else passed++;
        repeat (2) step();
        tmr_tled = 12'h000;
        step();
        checks++;
        if (buzzer !== 1'b1 || tmr_start !== 1'b0 || busy !== 1'b1)
            $display("[TB] FAIL norm_done_entry: buzzer=%b start=%b busy=%b, want 1 0 1", buzzer, tmr_start, busy);
        else passed++;
        n = 0;
        while (buzzer === 1'b1 && n < 5000) begin
            step();
            n++;
        end
        checks++;
        if (n != 4000)
            $display("[TB] FAIL norm_buzzer_len: buzzer high %0d clocks, want 4000", n);
        else passed++;
        checks++;
        if (busy !== 1'b0 || buzzer !== 1'b0)
            $display("[TB] FAIL norm_idle: busy=%b buzzer=%b, want 0 0", busy, buzzer);
        else passed++;
        checks++;
        if (write_count != wc + 2)
            $display("[TB] FAIL norm_write_count: %0d writes, want 2", write_count - wc);
        else passed++;
    endtask

    task automatic test_pause_resume();
        int wc;
        run_to_cook();
        wc = write_count;
        pulse_stop();
        checks++;
        if (tmr_start !== 1'b0 || tmr_dc !== 8'd0 || busy !== 1'b1)
            $display("[TB] FAIL pause_entry: start=%b dc=%0d busy=%b, want 0 0 1", tmr_start, tmr_dc, busy);
        else passed++;
        repeat (3) step();
        checks++;
        if (write_count != wc || tmr_write !== 1'b0)
            $display("[TB] FAIL pause_no_write: writes=%0d write=%b, want 0 0", write_count - wc, tmr_write);
        else passed++;
        pulse_start();
        checks++;
        if (tmr_start !== 1'b1 || tmr_dc !== 8'd100)
            $display("[TB] FAIL resume_cook: start=%b dc=%0d, want 1 100", tmr_start, tmr_dc);
        else passed++;
        step();
        checks++;
        if (write_count != wc || tmr_start !== 1'b1)
            $display("[TB] FAIL resume_no_reload: writes=%0d start=%b, want 0 1", write_count - wc, tmr_start);
        else passed++;
        pulse_stop();
        pulse_stop();
        step();
        checks++;
        if (tmr_write !== 1'b1 || tmr_time !== 10'd0 || tmr_start !== 1'b0)
            $display("[TB] FAIL abort_write_zero: write=%b time=%0d start=%b, want 1 0 0", tmr_write, tmr_time, tmr_start);
        else passed++;
        step();
        checks++;
        if (busy !== 1'b0 || tmr_write !== 1'b0)
            $display("[TB] FAIL abort_idle: busy=%b write=%b, want 0 0", busy, tmr_write);
        else passed++;
    endtask

    task automatic test_handshake();
        int n;
        ack_delay = 5;
        tmr_tled  = 12'h010;
        pulse_start();
        step();
        time_unstable = 1'b0;
        n = 0;
        while (tmr_write === 1'b1 && n < 30) begin
            n++;
            step();
        end
        checks++;
        if (n != 5)
            $display("[TB] FAIL hs_delayed_len: write high %0d clocks, want 5", n);
        else passed++;
        checks++;
        if (time_unstable || last_time !== 10'd10)
            $display("[TB] FAIL hs_time_stable: unstable=%0b time=%0d, want 0 10", time_unstable, last_time);
        else passed++;
        checks++;
        if (tmr_start !== 1'b1 || tmr_dc !== 8'd200)
            $display("[TB] FAIL hs_delayed_preheat: start=%b dc=%0d, want 1 200", tmr_start, tmr_dc);
        else passed++;
        pulse_stop();
        pulse_stop();
        n = 0;
        while (busy === 1'b1 && n < 30) begin
            step();
            n++;
        end
        checks++;
        if (busy !== 1'b0)
            $display("[TB] FAIL hs_abort_idle: busy=%b after %0d clocks, want 0", busy, n);
        else passed++;
        ack_delay  = 1;
        ack_enable = 1'b0;
        pulse_start();
        step();
        checks++;
        if (tmr_write !== 1'b1)
            $display("[TB] FAIL hs_noack_write: write=%b, want 1", tmr_write);
        else passed++;
        n = 0;
        while (error !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (n != 16)
            $display("[TB] FAIL hs_timeout_len: error after %0d clocks, want 16", n);
        else passed++;
        checks++;
        if (tmr_start !== 1'b0 || tmr_write !== 1'b0 || busy !== 1'b1)
            $display("[TB] FAIL hs_error_outputs: start=%b write=%b busy=%b, want 0 0 1", tmr_start, tmr_write, busy);
        else passed++;
        pulse_start();
        checks++;
        if (error !== 1'b1 || tmr_write !== 1'b0)
            $display("[TB] FAIL hs_error_ignore_start: error=%b write=%b, want 1 0", error, tmr_write);
        else passed++;
        pulse_stop();
        checks++;
        if (error !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL hs_error_clear: error=%b busy=%b, want 0 0", error, busy);
        else passed++;
        ack_enable = 1'b1;
    endtask

    task automatic test_boundaries();
        int wc;
        enter_key(10'd0, 8'd255);
        wc = write_count;
        pulse_start();
        step();
        checks++;
        if (busy !== 1'b0 || write_count != wc)
            $display("[TB] FAIL bnd_start_time0: busy=%b writes=%0d, want 0 0", busy, write_count - wc);
        else passed++;
        enter_key(10'd5, 8'd255);
        run_to_cook();
        checks++;
        if (tmr_dc !== 8'd200 || last_time !== 10'd5)
            $display("[TB] FAIL bnd_dc_clamp: dc=%0d time=%0d, want 200 5", tmr_dc, last_time);
        else passed++;
        enter_key(10'd7, 8'd50);
        checks++;
        if (tmr_dc !== 8'd200 || tmr_start !== 1'b1)
            $display("[TB] FAIL bnd_key_ignored_cook: dc=%0d start=%b, want 200 1", tmr_dc, tmr_start);
        else passed++;
        pulse_stop();
        start_btn = 1'b1;
        stop_btn  = 1'b1;
        step();
        start_btn = 1'b0;
        stop_btn  = 1'b0;
        checks++;
        if (tmr_start !== 1'b0 || busy !== 1'b1)
            $display("[TB] FAIL bnd_start_stop_state: start=%b busy=%b, want 0 1", tmr_start, busy);
        else passed++;
        step();
        checks++;
        if (tmr_write !== 1'b1 || tmr_time !== 10'd0)
            $display("[TB] FAIL bnd_start_stop_zero: write=%b time=%0d, want 1 0", tmr_write, tmr_time);
        else passed++;
        step();
        tmr_tled = 12'h000;
        pulse_start();
        step();
        step();
        step();
        checks++;
        if (tmr_start !== 1'b1 || tmr_dc !== 8'd200)
            $display("[TB] FAIL bnd_zero_skip_first: start=%b dc=%0d, want 1 200", tmr_start, tmr_dc);
        else passed++;
        step();
        checks++;
        if (tmr_start !== 1'b0 || busy !== 1'b1)
            $display("[TB] FAIL bnd_zero_second_cycle: start=%b busy=%b, want 0 1", tmr_start, busy);
        else passed++;
        step();
        checks++;
        if (tmr_write !== 1'b1 || tmr_time !== 10'd5)
            $display("[TB] FAIL bnd_latch_persist: write=%b time=%0d, want 1 5", tmr_write, tmr_time);
        else passed++;
        tmr_tled = 12'h005;
        step();
        pulse_stop();
        pulse_stop();
        step();
        step();
    endtask

    task automatic test_done_stop();
        run_to_cook();
        tmr_tled = 12'h000;
        step();
        pulse_start();
        checks++;
        if (buzzer !== 1'b1 || busy !== 1'b1 || tmr_write !== 1'b0)
            $display("[TB] FAIL done_start_ignored: buzzer=%b busy=%b write=%b, want 1 1 0", buzzer, busy, tmr_write);
        else passed++;
        pulse_stop();
        checks++;
        if (buzzer !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL done_stop_silence: buzzer=%b busy=%b, want 0 0", buzzer, busy);
        else passed++;
    endtask

    task automatic test_async_reset();
        int wc;
        run_to_cook();
        wc = write_count;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({tmr_write, tmr_start, busy, buzzer, error, tmr_time, tmr_dc} !== '0)
            $display("[TB] FAIL async_reset_outputs: write=%b start=%b busy=%b buzzer=%b error=%b time=%0d dc=%0d, want all 0",
                     tmr_write, tmr_start, busy, buzzer, error, tmr_time, tmr_dc);
        else passed++;
        step();
        step();
        reset = 1'b0;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || write_count != wc)
            $display("[TB] FAIL async_reset_idle: busy=%b writes=%0d, want 0 0", busy, write_count - wc);
        else passed++;
        pulse_start();
        checks++;
        if (busy !== 1'b0)
            $display("[TB] FAIL reset_clears_latch: busy=%b, want 0", busy);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_normal_cycle();
        test_pause_resume();
        test_handshake();
        test_boundaries();
        test_done_stop();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
